// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath blocks.
//
// Contents:
//   TPU_NUM_COLS        default number of bias units in an output row
//   TPU_DATA_W          default signed bias width
//   bias_loader_state_t state encoding of the bias loader FSM
package tpu_pkg;

    localparam int TPU_NUM_COLS = 4;
    localparam int TPU_DATA_W   = 16;

    // IDLE  : accepting host writes, waiting for start
    // SEND  : shifting buffered biases into the cascade, last column first
    // SWITCH: single-cycle promote pulse to every bias unit
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SWITCH = 2'd2
    } bias_loader_state_t;

endpackage

// File: rtl/bias_loader.sv
// bias_loader: transmitter end of the bias load chain.
//
// The host writes one bias per column (column 0 first) into an internal
// buffer. On start with a full buffer the biases are shifted onto the
// cascade, last column first, so that after NUM_COLS load cycles unit k
// holds buffer entry k. A one-cycle switch pulse then promotes every
// unit's inactive bias to active, followed by a one-cycle done pulse.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   wr_valid         host bias write valid
//   wr_ready         loader can accept a write
//   wr_data          signed bias, written in column order
//   start            single-cycle request to send the buffered biases
//   flush            discard buffer contents (idle only)
//   bias_load_out    global load strobe to all bias units
//   bias_scalar_out  value into column 0's scalar input (0 when not loading)
//   bias_switch_out  one-cycle inactive->active promote pulse
//   busy             SEND or SWITCH in progress
//   done             one-cycle pulse on the cycle after the switch pulse
//
// Build option:
//   BIAS_LOADER_RELOAD_EN  keep buffer and count after done so a later start
//                          re-sends the same biases; only flush or reset
//                          clear the count.
//
// All outputs are registered: the combinational process computes the value
// each output takes after the next edge.
module bias_loader
    import tpu_pkg::*;
#(
    parameter int NUM_COLS = TPU_NUM_COLS,
    parameter int DATA_W   = TPU_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     start,
    input  logic                     flush,
    output logic                     bias_load_out,
    output logic signed [DATA_W-1:0] bias_scalar_out,
    output logic                     bias_switch_out,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(NUM_COLS + 1);
    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_COLS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COLS - 1);

    bias_loader_state_t state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [IDX_W-1:0] idx, idx_next, idx_dec;
    logic signed [DATA_W-1:0] bias_buf [NUM_COLS];
    logic wr_en;

    logic                     wr_ready_next;
    logic                     load_next;
    logic signed [DATA_W-1:0] scalar_next;
    logic                     switch_next;
    logic                     busy_next;
    logic                     done_next;

    assign idx_dec = idx - IDX_W'(1);

    // Next-state and next-output logic. idx always names the buffer entry
    // currently on bias_scalar_out, so reaching idx==0 in SEND means the
    // last load cycle is being shown and the next cycle is the switch.
    // In IDLE, flush has priority over everything; start only launches on
    // the pre-write count, so a write that fills the buffer cannot also
    // launch it in the same cycle.
    always_comb begin
        state_next    = state;
        count_next    = count;
        idx_next      = idx;
        wr_en         = 1'b0;
        load_next     = 1'b0;
        scalar_next   = '0;
        switch_next   = 1'b0;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        wr_ready_next = 1'b0;

        case (state)
            IDLE: begin
                if (flush) begin
                    count_next = '0;
                end else if (start && (count == FULL_COUNT)) begin
                    state_next  = SEND;
                    idx_next    = LAST_IDX;
                    load_next   = 1'b1;
                    scalar_next = bias_buf[LAST_IDX];
                    busy_next   = 1'b1;
                end else if (wr_valid && (count < FULL_COUNT)) begin
                    wr_en      = 1'b1;
                    count_next = count + CNT_W'(1);
                end
            end
            SEND: begin
                busy_next = 1'b1;
                if (idx == '0) begin
                    state_next  = SWITCH;
                    switch_next = 1'b1;
                end else begin
                    idx_next    = idx_dec;
                    load_next   = 1'b1;
                    scalar_next = bias_buf[idx_dec];
                end
            end
            SWITCH: begin
                state_next = IDLE;
                done_next  = 1'b1;
                idx_next   = '0;
`ifdef BIAS_LOADER_RELOAD_EN
                count_next = count;
`else
                count_next = '0;
`endif
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
                idx_next   = '0;
            end
        endcase

        wr_ready_next = (state_next == IDLE) && (count_next < FULL_COUNT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            idx             <= '0;
            wr_ready        <= 1'b1;
            bias_load_out   <= 1'b0;
            bias_scalar_out <= '0;
            bias_switch_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_next;
            count           <= count_next;
            idx             <= idx_next;
            wr_ready        <= wr_ready_next;
            bias_load_out   <= load_next;
            bias_scalar_out <= scalar_next;
            bias_switch_out <= switch_next;
            busy            <= busy_next;
            done            <= done_next;
        end
    end

    // Bias storage has no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bias_buf[count[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule
